hwag_angle_channel: RTL and testbench
=====================================

Name: hwag_angle_channel

Overview:
- Angle-triggered output channel that consumes the ACNT2 angle count and the HWAG synchronised flag produced by the angle generator.
- Drives one ignition/injection output that asserts at a programmed on-angle and deasserts at an off-angle or on a max-on-time timeout.
- Angles are double-buffered: CPU writes go to shadow registers, which transfer to the active set only at safe points.
- One instance per physical channel, placed directly downstream of the angle generator.

Parameters:
- ANGLE_W, 24, width of angle count and angle registers.
- TMR_W, 24, width of the max-on-time counter (clk cycles).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- hwag_start  in  1  angle generator synchronised. Level.
- acnt  in  ANGLE_W  current angle count (ACNT2), range 0..acnt_top.
- ch_ena  in  1  channel enable.
- sh_we  in  1  single-cycle strobe that writes all shadow registers.
- sh_on_angle  in  ANGLE_W  shadow on-angle.
- sh_off_angle  in  ANGLE_W  shadow off-angle.
- sh_max_on  in  TMR_W  shadow max on-time in clk cycles. 0 means no limit.
- ch_out  out  1  channel output, registered.
- upd_pending  out  1  shadow written but not yet transferred.
- on_if  out  1  1-cycle pulse when ch_out rises.
- off_if  out  1  1-cycle pulse when ch_out falls by angle.
- tmo_if  out  1  1-cycle pulse when ch_out falls by timeout.

Behaviour:
- Reset: all outputs 0; state IDLE; active and shadow registers 0; acnt_q 0; timer 0.
- acnt_q registers acnt every cycle. step = (acnt != acnt_q). Angle events are evaluated only on step cycles, so a held angle never retriggers.
- on_hit = step & (acnt == on_act). off_hit = step & (acnt == off_act).
- States:
  - IDLE: ch_out=0. Go to WAIT_ON when ch_ena & hwag_start.
  - WAIT_ON: ch_out=0. On on_hit & (on_act != off_act), go to ON, set ch_out and on_if next cycle, clear timer.
  - ON: ch_out=1; timer increments each clk.
    - On off_hit, go to WAIT_ON, clear ch_out, pulse off_if.
    - Else, if max_act != 0 and timer == max_act-1, go to WAIT_ON, clear ch_out, pulse tmo_if. Total on-time is exactly max_act cycles.
  - Any state: ~ch_ena | ~hwag_start forces IDLE with ch_out=0 next cycle. No off_if/tmo_if is generated. This has priority over all events.
- Latency: ch_out changes one clk after the acnt step that matches.
- Wrap: off_act < on_act is legal. The window spans acnt_top→0, and no special logic is needed because events are equality-based.
- on_act == off_act: the channel never fires. This is a zero-width window.
- on_hit and off_hit in the same cycle can only occur when the angles are equal, which is covered by the rule above.
- Shadow transfer (on/off/max → active):
  - sh_we loads the shadow and sets upd_pending.
  - Transfer happens on the first cycle where upd_pending and either:
    - state==IDLE, or
    - state==WAIT_ON and step and acnt==0.
  - ON defers the transfer. After the off or timeout event, the next acnt==0 step transfers.
  - The transfer clears upd_pending. A transfer takes effect for hit evaluation in the following cycle.
- sh_we in the same cycle as a transfer: the new shadow value is written and upd_pending stays 1. The transferred value is the pre-write shadow.
- Timer saturates at its maximum; no wrap.
- rst mid-pulse: ch_out drops next edge and no pulses are issued.

Decomposition:
- hwag_pkg holds:
  - state enum: CH_IDLE, CH_WAIT_ON, CH_ON.
  - ANGLE_W/TMR_W defaults.
- Natural sub-module: hwag_ch_shadow. It holds the shadow/active register pair, upd_pending and the transfer-condition logic. The FSM, edge detect and timer stay in the top.

Test Plan:
- Normal pulse: on=100, off=110, max=0. Step acnt 95→115 with one value every 8 clk → ch_out rises one clk after acnt=100 appears and falls one clk after acnt=110; one on_if and one off_if.
- Wrap window: top=719, on=715, off=5. Step through 719→0 → ch_out stays high across the wrap and falls after acnt=5.
- Timeout: on=100, off=200, max=20, slow acnt → ch_out high exactly 20 clk; tmo_if pulses; no off_if at 200; acnt=100 held does not retrigger.
- Deferred update: with ch_out high, write on=300 → upd_pending=1 until the first acnt=0 step after off. The next pulse then fires at 300, not 100.
- Loss of sync: drop hwag_start while ON → ch_out=0 next clk, no off_if/tmo_if, state IDLE. Re-assert → next pulse fires normally.
- Degenerate and reset: on=off=50 → never fires. Assert rst while ON → all outputs 0 next clk and upd_pending=0.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared types and defaults for the HWAG angle-triggered output channel.
//   ch_state_e  : channel FSM states (idle, armed/waiting for on-angle, output on)
//   *_DEF       : default widths for angle and max-on-time counters
package hwag_pkg;
  localparam int ANGLE_W_DEF = 24;
  localparam int TMR_W_DEF   = 24;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_WAIT_ON = 2'd1,
    CH_ON      = 2'd2
  } ch_state_e;
endpackage

// File: rtl/hwag_ch_shadow.sv
// Shadow/active register pair for on-angle, off-angle and max-on-time.
// CPU writes land in the shadow set; the active set is reloaded only at safe
// points (channel idle, or armed and the angle count steps onto 0).
//   clk, rst         : clock, synchronous active-high reset
//   sh_we            : strobe loading all shadow registers
//   sh_on/off/max    : shadow write data
//   state            : current channel FSM state
//   step, acnt_zero  : angle count moved this cycle / current count is 0
//   on/off/max_act   : active values used for hit evaluation
//   upd_pending      : shadow holds data not yet transferred
module hwag_ch_shadow
  import hwag_pkg::*;
#(
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int TMR_W   = TMR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sh_we,
  input  logic [ANGLE_W-1:0] sh_on_angle,
  input  logic [ANGLE_W-1:0] sh_off_angle,
  input  logic [TMR_W-1:0]   sh_max_on,
  input  ch_state_e          state,
  input  logic               step,
  input  logic               acnt_zero,
  output logic [ANGLE_W-1:0] on_act,
  output logic [ANGLE_W-1:0] off_act,
  output logic [TMR_W-1:0]   max_act,
  output logic               upd_pending
);
  logic [ANGLE_W-1:0] on_sh, off_sh;
  logic [TMR_W-1:0]   max_sh;
  logic               xfer;

  // ON never transfers: changing the off-angle mid-pulse could skip the
  // falling edge entirely.
  assign xfer = upd_pending &&
                ((state == CH_IDLE) || (state == CH_WAIT_ON && step && acnt_zero));

  always_ff @(posedge clk) begin
    if (rst) begin
      on_sh       <= '0;
      off_sh      <= '0;
      max_sh      <= '0;
      on_act      <= '0;
      off_act     <= '0;
      max_act     <= '0;
      upd_pending <= 1'b0;
    end else begin
      // Transfer copies the pre-write shadow; a coincident write stays pending.
      if (xfer) begin
        on_act  <= on_sh;
        off_act <= off_sh;
        max_act <= max_sh;
      end
      if (sh_we) begin
        on_sh  <= sh_on_angle;
        off_sh <= sh_off_angle;
        max_sh <= sh_max_on;
      end
      upd_pending <= sh_we | (upd_pending & ~xfer);
    end
  end
endmodule

// File: rtl/hwag_angle_channel.sv
// Angle-triggered ignition/injection output channel.
// Output rises when the angle count steps onto the active on-angle and falls
// when it steps onto the off-angle or when the max-on-time expires.
//   clk, rst          : clock, synchronous active-high reset
//   hwag_start        : angle generator synchronised (level)
//   acnt              : current angle count (ACNT2)
//   ch_ena            : channel enable
//   sh_we, sh_*       : shadow register write port
//   ch_out            : registered channel output
//   upd_pending       : shadow written, not yet active
//   on_if/off_if/tmo_if : 1-cycle pulses for rise, angle fall, timeout fall
module hwag_angle_channel
  import hwag_pkg::*;
#(
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int TMR_W   = TMR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hwag_start,
  input  logic [ANGLE_W-1:0] acnt,
  input  logic               ch_ena,
  input  logic               sh_we,
  input  logic [ANGLE_W-1:0] sh_on_angle,
  input  logic [ANGLE_W-1:0] sh_off_angle,
  input  logic [TMR_W-1:0]   sh_max_on,
  output logic               ch_out,
  output logic               upd_pending,
  output logic               on_if,
  output logic               off_if,
  output logic               tmo_if
);
  ch_state_e          state, state_nxt;
  logic [ANGLE_W-1:0] acnt_q, on_act, off_act;
  logic [TMR_W-1:0]   max_act, timer;
  logic               step, on_hit, off_hit, sync_ok, tmo_hit;
  logic               on_nxt, off_nxt, tmo_nxt;

  // Events only on a changing count, so a held angle cannot retrigger.
  assign step    = (acnt != acnt_q);
  assign on_hit  = step && (acnt == on_act);
  assign off_hit = step && (acnt == off_act);
  assign sync_ok = ch_ena && hwag_start;
  // Timer is 0 on the first ON cycle, so this yields exactly max_act cycles high.
  assign tmo_hit = (max_act != '0) && (timer == max_act - TMR_W'(1));

  hwag_ch_shadow #(.ANGLE_W(ANGLE_W), .TMR_W(TMR_W)) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .sh_we        (sh_we),
    .sh_on_angle  (sh_on_angle),
    .sh_off_angle (sh_off_angle),
    .sh_max_on    (sh_max_on),
    .state        (state),
    .step         (step),
    .acnt_zero    (acnt == '0),
    .on_act       (on_act),
    .off_act      (off_act),
    .max_act      (max_act),
    .upd_pending  (upd_pending)
  );

  always_comb begin
    state_nxt = state;
    on_nxt    = 1'b0;
    off_nxt   = 1'b0;
    tmo_nxt   = 1'b0;
    if (!sync_ok) begin
      // Loss of enable/sync wins over every event and is silent.
      state_nxt = CH_IDLE;
    end else begin
      case (state)
        CH_IDLE:    state_nxt = CH_WAIT_ON;
        CH_WAIT_ON: if (on_hit && (on_act != off_act)) begin
                      state_nxt = CH_ON;
                      on_nxt    = 1'b1;
                    end
        CH_ON:      if (off_hit) begin
                      state_nxt = CH_WAIT_ON;
                      off_nxt   = 1'b1;
                    end else if (tmo_hit) begin
                      state_nxt = CH_WAIT_ON;
                      tmo_nxt   = 1'b1;
                    end
        default:    state_nxt = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CH_IDLE;
      acnt_q <= '0;
      timer  <= '0;
      ch_out <= 1'b0;
      on_if  <= 1'b0;
      off_if <= 1'b0;
      tmo_if <= 1'b0;
    end else begin
      state  <= state_nxt;
      acnt_q <= acnt;
      ch_out <= (state_nxt == CH_ON);
      on_if  <= on_nxt;
      off_if <= off_nxt;
      tmo_if <= tmo_nxt;
      if (on_nxt)
        timer <= '0;
      else if (state == CH_ON && timer != '1)
        timer <= timer + TMR_W'(1);
    end
  end
endmodule

// File: tb/tb_hwag_angle_channel.sv
// Self-checking bench for hwag_angle_channel: a fixed vector table, scenario
// sequences with pulse/high-time counters, and a random phase. Every cycle is
// also compared against a behavioural model of the channel.
module tb_hwag_angle_channel;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hwag_start = 1'b0;
  logic [23:0] acnt = '0;
  logic        ch_ena = 1'b0;
  logic        sh_we = 1'b0;
  logic [23:0] sh_on_angle = '0, sh_off_angle = '0, sh_max_on = '0;
  logic        ch_out, upd_pending, on_if, off_if, tmo_if;

  int vectors = 0, miscompares = 0;
  int n_on = 0, n_off = 0, n_tmo = 0, n_hi = 0;

  // model state: running = sync seen, high = output asserted, ontime = cycles high so far
  int  m_acnt_q, m_on, m_off, m_max, s_on, s_off, s_max, ontime;
  bit  running, high, pend, p_on, p_off, p_tmo;

  always #5 clk = ~clk;

  hwag_angle_channel dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .acnt(acnt), .ch_ena(ch_ena),
    .sh_we(sh_we), .sh_on_angle(sh_on_angle), .sh_off_angle(sh_off_angle),
    .sh_max_on(sh_max_on), .ch_out(ch_out), .upd_pending(upd_pending),
    .on_if(on_if), .off_if(off_if), .tmo_if(tmo_if)
  );

  function automatic logic [4:0] outs();
    return {ch_out, upd_pending, on_if, off_if, tmo_if};
  endfunction

  task automatic model_step();
    int  a;
    bit  stepped, ok, xfer;
    a = int'(acnt);
    p_on = 0; p_off = 0; p_tmo = 0;
    if (rst) begin
      running = 0; high = 0; pend = 0; ontime = 0; m_acnt_q = 0;
      m_on = 0; m_off = 0; m_max = 0; s_on = 0; s_off = 0; s_max = 0;
      return;
    end
    stepped = (a != m_acnt_q);
    ok      = ch_ena && hwag_start;
    xfer    = pend && (!running || (!high && stepped && a == 0));
    if (!ok) begin
      running = 0; high = 0;
    end else if (!running) begin
      running = 1;
    end else if (!high) begin
      if (stepped && a == m_on && m_on != m_off) begin
        high = 1; ontime = 1; p_on = 1;
      end
    end else if (stepped && a == m_off) begin
      high = 0; p_off = 1;
    end else if (m_max != 0 && ontime == m_max) begin
      high = 0; p_tmo = 1;
    end else begin
      ontime++;
    end
    if (xfer) begin m_on = s_on; m_off = s_off; m_max = s_max; end
    if (sh_we) begin
      s_on = int'(sh_on_angle); s_off = int'(sh_off_angle); s_max = int'(sh_max_on);
    end
    pend = sh_we || (pend && !xfer);
    m_acnt_q = a;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock: predict, clock, sample #1 later, compare against model
  task automatic tick();
    logic [4:0] exp;
    model_step();
    exp = {high, pend, p_on, p_off, p_tmo};
    @(posedge clk);
    #1;
    n_on += int'(on_if); n_off += int'(off_if); n_tmo += int'(tmo_if); n_hi += int'(ch_out);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL model {out,pend,on,off,tmo} acnt=%0d: got %b expected %b (t=%0t)",
               acnt, outs(), exp, $time);
    end
  endtask

  task automatic clr();
    n_on = 0; n_off = 0; n_tmo = 0; n_hi = 0;
  endtask

  task automatic sweep(input int from, input int to, input int hold);
    for (int a = from; a <= to; a++) begin
      acnt = 24'(a);
      repeat (hold) tick();
    end
  endtask

  // load through IDLE so the active set updates immediately, then re-arm
  task automatic load(input int on, input int off, input int mx);
    ch_ena = 0;
    sh_we = 1; sh_on_angle = 24'(on); sh_off_angle = 24'(off); sh_max_on = 24'(mx);
    tick();
    sh_we = 0;
    tick();
    ch_ena = 1; hwag_start = 1;
    tick();
  endtask

  typedef struct {
    bit         rst, ena, start, we;
    int         acnt;
    logic [4:0] exp;  // {ch_out, upd_pending, on_if, off_if, tmo_if}
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(bit r, bit e, bit s, bit w, int a, logic [4:0] x);
    vec_t v;
    v.rst = r; v.ena = e; v.start = s; v.we = w; v.acnt = a; v.exp = x;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 5'b00000);
    tbl[1]  = mk(0, 0, 0, 1, 0, 5'b01000);
    tbl[2]  = mk(0, 0, 0, 0, 0, 5'b00000);
    tbl[3]  = mk(0, 1, 1, 0, 0, 5'b00000);
    tbl[4]  = mk(0, 1, 1, 0, 1, 5'b00000);
    tbl[5]  = mk(0, 1, 1, 0, 3, 5'b10100);
    tbl[6]  = mk(0, 1, 1, 0, 3, 5'b10000);
    tbl[7]  = mk(0, 1, 1, 0, 4, 5'b10000);
    tbl[8]  = mk(0, 1, 1, 0, 6, 5'b00010);
    tbl[9]  = mk(0, 1, 1, 0, 3, 5'b10100);
    tbl[10] = mk(0, 1, 0, 0, 4, 5'b00000);
    tbl[11] = mk(0, 1, 1, 0, 5, 5'b00000);
    tbl[12] = mk(0, 1, 1, 0, 3, 5'b10100);
    tbl[13] = mk(1, 1, 1, 0, 3, 5'b00000);

    #2;
    sh_on_angle = 24'd3; sh_off_angle = 24'd6; sh_max_on = '0;
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; ch_ena = tbl[i].ena; hwag_start = tbl[i].start;
      sh_we = tbl[i].we; acnt = 24'(tbl[i].acnt);
      tick();
      check($sformatf("table[%0d]", i), int'(outs()), int'(tbl[i].exp));
    end
    rst = 0; sh_we = 0;

    // normal pulse
    load(100, 110, 0); clr();
    sweep(95, 115, 8);
    check("normal on_if", n_on, 1);
    check("normal off_if", n_off, 1);
    check("normal high cycles", n_hi, 80);

    // wrap window across 719 -> 0
    acnt = 24'd700; tick();
    load(715, 5, 0); clr();
    sweep(710, 719, 4);
    sweep(0, 10, 4);
    check("wrap on_if", n_on, 1);
    check("wrap off_if", n_off, 1);
    check("wrap high cycles", n_hi, 40);

    // timeout; acnt held at 100 must not retrigger
    load(100, 200, 20); clr();
    sweep(95, 99, 2);
    sweep(100, 100, 60);
    sweep(101, 210, 2);
    check("tmo high cycles", n_hi, 20);
    check("tmo tmo_if", n_tmo, 1);
    check("tmo off_if", n_off, 0);
    check("tmo on_if", n_on, 1);

    // deferred update while high
    load(100, 110, 0); clr();
    sweep(95, 105, 2);
    sh_we = 1; sh_on_angle = 24'd300; sh_off_angle = 24'd310; sh_max_on = '0;
    tick();
    sh_we = 0;
    check("defer pending while on", int'(upd_pending), 1);
    sweep(106, 719, 1);
    check("defer pending before 0", int'(upd_pending), 1);
    acnt = 0; tick();
    check("defer pending after 0", int'(upd_pending), 0);
    sweep(1, 320, 1);
    check("defer on_if", n_on, 2);
    check("defer off_if", n_off, 2);

    // loss of sync while on
    load(100, 110, 0); clr();
    sweep(95, 103, 2);
    hwag_start = 0; tick();
    check("nosync ch_out", int'(ch_out), 0);
    tick();
    hwag_start = 1;
    sweep(104, 719, 1);
    sweep(0, 115, 1);
    check("nosync on_if", n_on, 2);
    check("nosync off_if", n_off, 1);
    check("nosync tmo_if", n_tmo, 0);

    // degenerate window
    load(50, 50, 0); clr();
    sweep(40, 60, 2);
    check("degenerate on_if", n_on, 0);
    check("degenerate high", n_hi, 0);

    // reset while on with a pending write
    load(100, 110, 0);
    sweep(95, 103, 2);
    sh_we = 1; sh_on_angle = 24'd7; tick(); sh_we = 0;
    rst = 1; tick();
    check("reset outputs", int'(outs()), 0);
    rst = 0;

    // random phase over a small angle range
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst        = ($urandom_range(0, 199) == 0);
      ch_ena     = ($urandom_range(0, 59) != 0);
      hwag_start = ($urandom_range(0, 59) != 0);
      sh_we      = ($urandom_range(0, 19) == 0);
      sh_on_angle  = 24'($urandom_range(0, 15));
      sh_off_angle = 24'($urandom_range(0, 15));
      sh_max_on    = 24'($urandom_range(0, 6));
      r = $urandom_range(0, 9);
      if (r < 7)       acnt = (acnt == 24'd15) ? 24'd0 : acnt + 24'd1;
      else if (r == 9) acnt = 24'($urandom_range(0, 15));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
